// File: rtl/ariane_pkg.sv
// Shared types for the commit-side sequencing logic.
//
// fence_type_t encodes the memory-ordering instruction handed over by the
// commit stage. Encodings 5..7 are reserved and are treated as no-ops by
// consumers.
package ariane_pkg;

  typedef enum logic [2:0] {
    FENCE       = 3'd0,
    FENCE_I     = 3'd1,
    SFENCE_VMA  = 3'd2,
    HFENCE_VVMA = 3'd3,
    HFENCE_GVMA = 3'd4
  } fence_type_t;

  // True for the two hypervisor fences, which collapse to no-ops when the
  // H extension is absent.
  function automatic logic is_hfence(fence_type_t t);
    return (t == HFENCE_VVMA) || (t == HFENCE_GVMA);
  endfunction

endpackage

// File: rtl/fence_sequencer.sv
// fence_sequencer
//
// Multi-cycle sequencer for committed FENCE, FENCE.I, SFENCE.VMA,
// HFENCE.VVMA and HFENCE.GVMA. It accepts one request while idle and then
// walks the D$ flush handshake, the I$ invalidate window and the TLB flush
// pulse in order, halting commit until a one-cycle completion pulse. The
// flush controller only has to redirect the PC on set_pc_commit_o.
//
// All outputs are decoded from registered state (Moore); no input reaches
// an output combinationally.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   fence_req_i           request valid from commit (only honoured when ready)
//   fence_type_i          fence_type_t of the request
//   v_i                   virtualization mode, captured at accept
//   fence_ready_o         idle, a request can be accepted
//   flush_dcache_o        D$ flush request, held until ack or timeout
//   flush_dcache_ack_i    D$ flush done (ignored outside the D$ flush phase)
//   flush_icache_o        I$ invalidate, high for ICACHE_FLUSH_CYCLES cycles
//   flush_tlb_o           flush all TLB entries (one cycle)
//   flush_tlb_vvma_o      flush VS-stage entries (one cycle)
//   flush_tlb_gvma_o      flush G-stage entries (one cycle)
//   halt_o                stall commit while a fence is in flight
//   fence_done_o          one-cycle completion pulse
//   set_pc_commit_o       one-cycle PC redirect pulse, coincident with done
//   dack_timeout_o        sticky: a D$ ack timed out since reset
module fence_sequencer
  import ariane_pkg::*;
#(
  parameter bit          WT_DCACHE           = 1'b0,
  parameter bit          RVH                 = 1'b1,
  parameter int unsigned ICACHE_FLUSH_CYCLES = 2,
  parameter int unsigned DACK_TIMEOUT        = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       fence_req_i,
  input  logic [2:0] fence_type_i,
  input  logic       v_i,
  output logic       fence_ready_o,
  output logic       flush_dcache_o,
  input  logic       flush_dcache_ack_i,
  output logic       flush_icache_o,
  output logic       flush_tlb_o,
  output logic       flush_tlb_vvma_o,
  output logic       flush_tlb_gvma_o,
  output logic       halt_o,
  output logic       fence_done_o,
  output logic       set_pc_commit_o,
  output logic       dack_timeout_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DFLUSH = 3'd1;
  localparam logic [2:0] IFLUSH = 3'd2;
  localparam logic [2:0] TLB    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // One counter serves both the D$ ack timeout and the I$ window, since the
  // two phases never overlap; it is sized for the larger of the two.
  localparam int unsigned CNT_MAX_0 = (ICACHE_FLUSH_CYCLES > DACK_TIMEOUT) ?
                                      ICACHE_FLUSH_CYCLES : DACK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_0 > 2) ? CNT_MAX_0 : 2;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] ICF_LAST  = CNT_W'(ICACHE_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DACK_LAST =
    CNT_W'((DACK_TIMEOUT == 0) ? 0 : DACK_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fence_type_t      type_q, type_d;
  logic             v_q, v_d;
  logic             timeout_q, timeout_d;

  fence_type_t      req_type;
  logic             dack_expired;

  assign req_type     = fence_type_t'(fence_type_i);
  assign dack_expired = (DACK_TIMEOUT != 0) && (cnt_q == DACK_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    v_d       = v_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (fence_req_i) begin
          type_d = req_type;
          v_d    = v_i;
          cnt_d  = '0;
          case (req_type)
            FENCE:       state_d = WT_DCACHE ? DONE : DFLUSH;
            FENCE_I:     state_d = DFLUSH;
            SFENCE_VMA:  state_d = TLB;
            HFENCE_VVMA,
            HFENCE_GVMA: state_d = RVH ? TLB : DONE;
            default:     state_d = DONE;
          endcase
        end
      end

      DFLUSH: begin
        // An ack wins over an expiring timeout in the same cycle.
        if (flush_dcache_ack_i || dack_expired) begin
          if (!flush_dcache_ack_i) timeout_d = 1'b1;
          cnt_d   = '0;
          state_d = (type_q == FENCE_I) ? IFLUSH : DONE;
        end else if (DACK_TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      IFLUSH: begin
        if (cnt_q == ICF_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TLB:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      type_q    <= FENCE;
      v_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      v_q       <= v_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore output decode.
  logic in_tlb;
  assign in_tlb = (state_q == TLB);

  assign fence_ready_o    = (state_q == IDLE);
  assign halt_o           = (state_q != IDLE);
  assign flush_dcache_o   = (state_q == DFLUSH);
  assign flush_icache_o   = (state_q == IFLUSH);
  assign fence_done_o     = (state_q == DONE);
  assign set_pc_commit_o  = (state_q == DONE);
  assign dack_timeout_o   = timeout_q;

  // SFENCE.VMA issued in V-mode only touches the guest's VS-stage entries.
  assign flush_tlb_o      = in_tlb && (type_q == SFENCE_VMA) && !(RVH && v_q);
  assign flush_tlb_vvma_o = in_tlb && (((type_q == SFENCE_VMA) && RVH && v_q) ||
                                       (type_q == HFENCE_VVMA));
  assign flush_tlb_gvma_o = in_tlb && is_hfence(type_q) && (type_q == HFENCE_GVMA);

  // Commit must not present a fence while the sequencer is busy.
  a_no_req_when_busy : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(fence_req_i && !fence_ready_o)
  );

endmodule

// File: tb/tb_fence_sequencer.sv
// Self-checking bench for fence_sequencer.
//
// Two instances with different parameter sets run side by side:
//   u0: WT_DCACHE=0, RVH=1, ICACHE_FLUSH_CYCLES=2, DACK_TIMEOUT=0
//   u1: WT_DCACHE=1, RVH=0, ICACHE_FLUSH_CYCLES=3, DACK_TIMEOUT=8
// The reference model plans each request as a timeline of phases (cycle
// ranges) from the instruction rules and compares every cycle's outputs.
module tb_fence_sequencer;

  localparam int U0_WT = 0, U0_RVH = 1, U0_N = 2, U0_DACK = 0;
  localparam int U1_WT = 1, U1_RVH = 0, U1_N = 3, U1_DACK = 8;

  localparam logic [2:0] T_FENCE = 3'd0, T_FENCE_I = 3'd1, T_SFENCE = 3'd2;
  localparam logic [2:0] T_HVVMA = 3'd3, T_HGVMA = 3'd4;

  // Bit positions of the observed output vector.
  localparam int B_READY = 9, B_FD = 8, B_FI = 7, B_TLB = 6, B_VVMA = 5;
  localparam int B_GVMA = 4, B_HALT = 3, B_DONE = 2, B_SETPC = 1, B_TO = 0;
  localparam logic [9:0] IDLE_VEC = 10'b10_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0 = 0, req1 = 0, v0 = 0, v1 = 0, ack0 = 0, ack1 = 0;
  logic [2:0] ty0 = '0, ty1 = '0;
  logic [9:0] obs0, obs1;

  fence_sequencer #(
    .WT_DCACHE(1'(U0_WT)), .RVH(1'(U0_RVH)),
    .ICACHE_FLUSH_CYCLES(U0_N), .DACK_TIMEOUT(U0_DACK)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .fence_req_i(req0), .fence_type_i(ty0), .v_i(v0),
    .fence_ready_o(obs0[B_READY]), .flush_dcache_o(obs0[B_FD]),
    .flush_dcache_ack_i(ack0), .flush_icache_o(obs0[B_FI]),
    .flush_tlb_o(obs0[B_TLB]), .flush_tlb_vvma_o(obs0[B_VVMA]),
    .flush_tlb_gvma_o(obs0[B_GVMA]), .halt_o(obs0[B_HALT]),
    .fence_done_o(obs0[B_DONE]), .set_pc_commit_o(obs0[B_SETPC]),
    .dack_timeout_o(obs0[B_TO])
  );

  fence_sequencer #(
    .WT_DCACHE(1'(U1_WT)), .RVH(1'(U1_RVH)),
    .ICACHE_FLUSH_CYCLES(U1_N), .DACK_TIMEOUT(U1_DACK)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .fence_req_i(req1), .fence_type_i(ty1), .v_i(v1),
    .fence_ready_o(obs1[B_READY]), .flush_dcache_o(obs1[B_FD]),
    .flush_dcache_ack_i(ack1), .flush_icache_o(obs1[B_FI]),
    .flush_tlb_o(obs1[B_TLB]), .flush_tlb_vvma_o(obs1[B_VVMA]),
    .flush_tlb_gvma_o(obs1[B_GVMA]), .halt_o(obs1[B_HALT]),
    .fence_done_o(obs1[B_DONE]), .set_pc_commit_o(obs1[B_SETPC]),
    .dack_timeout_o(obs1[B_TO])
  );

  int checks = 0;
  int errors = 0;
  bit sticky [2];

  typedef struct {
    bit dfl;     // D$ flush phase present
    bit tlb;     // TLB phase present
    int dend;    // last cycle of the D$ flush phase
    bit to;      // D$ phase ends by timeout
    int done_c;  // cycle of the completion pulse
  } plan_t;

  function automatic int p_wt(int u);   return (u == 0) ? U0_WT   : U1_WT;   endfunction
  function automatic int p_rvh(int u);  return (u == 0) ? U0_RVH  : U1_RVH;  endfunction
  function automatic int p_n(int u);    return (u == 0) ? U0_N    : U1_N;    endfunction
  function automatic int p_dack(int u); return (u == 0) ? U0_DACK : U1_DACK; endfunction

  function automatic logic [9:0] get_obs(int u);
    return (u == 0) ? obs0 : obs1;
  endfunction

  task automatic drive(int u, logic req, logic [2:0] ty, logic v, logic ack);
    if (u == 0) begin req0 = req; ty0 = ty; v0 = v; ack0 = ack; end
    else        begin req1 = req; ty1 = ty; v1 = v; ack1 = ack; end
  endtask

  // Timeline of one request; cycle 0 is the accept cycle. ack_at < 1 means
  // the D$ never acknowledges.
  function automatic plan_t make_plan(int u, logic [2:0] ty, int ack_at);
    plan_t p;
    int last;
    p.dfl  = (ty == T_FENCE && p_wt(u) == 0) || (ty == T_FENCE_I);
    p.tlb  = (ty == T_SFENCE) || ((ty == T_HVVMA || ty == T_HGVMA) && p_rvh(u) != 0);
    p.dend = 0;
    p.to   = 1'b0;
    if (p.dfl) begin
      if (p_dack(u) != 0 && (ack_at < 1 || ack_at > p_dack(u))) begin
        p.dend = p_dack(u);
        p.to   = 1'b1;
      end else begin
        p.dend = ack_at;
      end
      last = p.dend + ((ty == T_FENCE_I) ? p_n(u) : 0);
    end else begin
      last = p.tlb ? 1 : 0;
    end
    p.done_c = last + 1;
    return p;
  endfunction

  function automatic logic [9:0] expect_out(int u, logic [2:0] ty, logic v,
                                            plan_t p, int c);
    logic [9:0] e;
    e = '0;
    e[B_READY] = (c == 0) || (c > p.done_c);
    e[B_HALT]  = (c >= 1) && (c <= p.done_c);
    e[B_FD]    = p.dfl && (c >= 1) && (c <= p.dend);
    e[B_FI]    = (ty == T_FENCE_I) && (c > p.dend) && (c <= p.dend + p_n(u));
    if (p.tlb && c == 1) begin
      if (ty == T_SFENCE) begin
        if (p_rvh(u) != 0 && v) e[B_VVMA] = 1'b1;
        else                    e[B_TLB]  = 1'b1;
      end else if (ty == T_HVVMA) e[B_VVMA] = 1'b1;
      else                        e[B_GVMA] = 1'b1;
    end
    e[B_DONE]  = (c == p.done_c);
    e[B_SETPC] = (c == p.done_c);
    e[B_TO]    = sticky[u] || (p.to && c > p.dend);
    return e;
  endfunction

  // Issues one request on instance u (which must be idle), checking every
  // cycle up to and including the first idle cycle afterwards. With noise
  // set, spurious acks are added in cycles where the D$ phase is not active.
  task automatic run_fence(string name, int u, logic [2:0] ty, logic v,
                           int ack_at, bit noise);
    plan_t      p;
    logic [9:0] exp_v, got;
    logic       ack;
    p = make_plan(u, ty, ack_at);
    for (int c = 0; c <= p.done_c + 1; c++) begin
      exp_v = expect_out(u, ty, v, p, c);
      got   = get_obs(u);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s u%0d type=%0d cycle %0d: got %b expected %b",
                 name, u, ty, c, got, exp_v);
      end
      if (c <= p.done_c) begin
        ack = (c == ack_at) ||
              (noise && (!p.dfl || c == 0 || c > p.dend) && $urandom_range(1, 0) == 1);
        drive(u, c == 0, ty, v, ack);
        @(posedge clk);
        @(negedge clk);
      end
    end
    drive(u, 1'b0, 3'd0, 1'b0, 1'b0);
    if (p.to) sticky[u] = 1'b1;
  endtask

  task automatic check_idle(string name, int u);
    logic [9:0] exp_v;
    exp_v = IDLE_VEC;
    exp_v[B_TO] = sticky[u];
    checks++;
    if (get_obs(u) !== exp_v) begin
      errors++;
      $display("FAIL %s u%0d: got %b expected %b", name, u, get_obs(u), exp_v);
    end
  endtask

  task automatic test_reset();
    sticky[0] = 1'b0;
    sticky[1] = 1'b0;
    #1;
    check_idle("reset_held", 0);
    check_idle("reset_held", 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_released", 0);
    check_idle("reset_released", 1);
  endtask

  task automatic test_fence_i_latency();
    // ack at cycle 4: D$ 1-4, I$ 5-6, done 7, ready 8.
    run_fence("fence_i_ack4", 0, T_FENCE_I, 1'b0, 4, 1'b0);
    run_fence("fence_i_ack1", 0, T_FENCE_I, 1'b1, 1, 1'b0);
  endtask

  task automatic test_fence();
    run_fence("fence_wt", 1, T_FENCE, 1'b0, 1, 1'b0);
    run_fence("fence_ack1", 0, T_FENCE, 1'b0, 1, 1'b0);
    run_fence("fence_ack_late", 0, T_FENCE, 1'b0, 6, 1'b1);
  endtask

  task automatic test_tlb();
    run_fence("sfence_v1", 0, T_SFENCE, 1'b1, 0, 1'b0);
    run_fence("sfence_v0", 0, T_SFENCE, 1'b0, 0, 1'b0);
    run_fence("hfence_gvma", 0, T_HGVMA, 1'b0, 0, 1'b0);
    run_fence("hfence_vvma", 0, T_HVVMA, 1'b1, 0, 1'b0);
    run_fence("hfence_vvma_norvh", 1, T_HVVMA, 1'b1, 0, 1'b0);
    run_fence("hfence_gvma_norvh", 1, T_HGVMA, 1'b0, 0, 1'b0);
    run_fence("sfence_v1_norvh", 1, T_SFENCE, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reserved();
    for (int t = 5; t < 8; t++)
      run_fence("reserved", 0, 3'(t), 1'b0, 0, 1'b1);
  endtask

  task automatic test_dack_timeout();
    // Ack in the very last allowed cycle beats the timeout.
    run_fence("dack_edge", 1, T_FENCE_I, 1'b0, 8, 1'b0);
    // No ack: D$ 1-8, timeout flag from cycle 9, I$ 9-11, done 12.
    run_fence("dack_timeout", 1, T_FENCE_I, 1'b0, -1, 1'b0);
    run_fence("dack_sticky", 1, T_SFENCE, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stray_ack();
    ack0 = 1'b1;
    ack1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("stray_ack", 0);
      check_idle("stray_ack", 1);
    end
    ack0 = 1'b0;
    ack1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_fence("b2b_fence_i", 0, T_FENCE_I, 1'b0, 2, 1'b0);
    run_fence("b2b_sfence", 0, T_SFENCE, 1'b0, 0, 1'b0);
    run_fence("b2b_fence_i_u1", 1, T_FENCE_I, 1'b0, 3, 1'b0);
    run_fence("b2b_fence_u1", 1, T_FENCE, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int         u, ack_at;
      logic [2:0] ty;
      logic       v;
      u  = int'($urandom_range(1, 0));
      ty = 3'($urandom_range(7, 0));
      v  = 1'($urandom_range(1, 0));
      if (u == 0) ack_at = int'($urandom_range(6, 1));
      else        ack_at = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(12, 1));
      run_fence("random", u, ty, v, ack_at, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    drive(0, 1'b1, T_FENCE_I, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, T_FENCE_I, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    got = get_obs(0);
    checks++;
    if (got[B_FI] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_iflush: flush_icache got %b expected 1", got[B_FI]);
    end
    // Assert reset mid-cycle with a D$ ack still pending.
    #2;
    rst_n = 1'b0;
    ack0  = 1'b1;
    sticky[0] = 1'b0;
    sticky[1] = 1'b0;
    #1;
    check_idle("reset_mid_async", 0);
    check_idle("reset_mid_async", 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("reset_mid_after", 0);
    end
    ack0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fence_i_latency();
    test_fence();
    test_tlb();
    test_reserved();
    test_dack_timeout();
    test_stray_ack();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
